// File: rtl/rbi_mem_l2_mmio.sv
// -----------------------------------------------------------------------------
// rbi_mem_l2_mmio
//   L2 ring-bus stop that bridges MMIO load/store requests onto a 64-bit MMIO
//   port. It sits as one register stage on the ring. MMIO requests addressed
//   to 0x0000_Fxxx_xxxx are pulled off the ring (the slot leaves empty). One
//   MMIO transaction runs at a time. The response is re-injected into the
//   next empty ring slot. All other slots pass through with one cycle of
//   latency.
//
// Configuration macro: RBI_MMIO_EXC_EN
//   defined   : mmioOK==FAULT produces response 8'h63 with data = mmioExcIn
//   undefined : FAULT behaves as OK, response 8'h60/8'h61 with data 0,
//               and mmioExcIn is ignored
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous reset, active low
//   memAddrIn    [47:0]   ring slot address in
//   memDataIn    [127:0]  ring slot data in
//   memOpmIn     [15:0]   ring opcode in ([7:0]==0 means an empty slot)
//   memSeqIn     [15:0]   ring sequence tag in
//   memAddrOut / memDataOut / memOpmOut / memSeqOut
//                         registered ring slot out
//   unitNodeId   [7:0]    node id of this stop, placed in response opm[15:8]
//   mmioAddr     [31:0]   MMIO address
//   mmioOpm      [4:0]    [4:3] 01=load 10=store, [2:0] size; 0 = idle
//   mmioOutData  [63:0]   store data
//   mmioInData   [63:0]   load data returned by the fabric
//   mmioOK       [1:0]    00 READY, 01 OK, 10 HOLD, 11 FAULT
//   mmioExcIn    [63:0]   fault code from the fabric
// -----------------------------------------------------------------------------
module rbi_mem_l2_mmio (
   input  logic         clock,
   input  logic         reset,
   input  logic [47:0]  memAddrIn,
   input  logic [127:0] memDataIn,
   input  logic [15:0]  memOpmIn,
   input  logic [15:0]  memSeqIn,
   output logic [47:0]  memAddrOut,
   output logic [127:0] memDataOut,
   output logic [15:0]  memOpmOut,
   output logic [15:0]  memSeqOut,
   input  logic [7:0]   unitNodeId,
   output logic [31:0]  mmioAddr,
   output logic [4:0]   mmioOpm,
   output logic [63:0]  mmioOutData,
   input  logic [63:0]  mmioInData,
   input  logic [1:0]   mmioOK,
   input  logic [63:0]  mmioExcIn
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   localparam logic [1:0] MMIO_READY = 2'b00;
   localparam logic [1:0] MMIO_OK    = 2'b01;
   localparam logic [1:0] MMIO_FAULT = 2'b11;

   localparam logic [7:0] RSP_LOAD  = 8'h60;
   localparam logic [7:0] RSP_STORE = 8'h61;
`ifdef RBI_MMIO_EXC_EN
   localparam logic [7:0] RSP_FAULT = 8'h63;
`endif

   logic [1:0]   stateReg, stateNext;
   logic [47:0]  reqAddrReg, reqAddrNext;
   logic [15:0]  reqSeqReg, reqSeqNext;
   logic         reqIsLoadReg, reqIsLoadNext;
   logic [7:0]   respCodeReg, respCodeNext;
   logic [63:0]  respDataReg, respDataNext;
   logic [31:0]  mmioAddrNext;
   logic [4:0]   mmioOpmNext;
   logic [63:0]  mmioOutDataNext;
   logic [47:0]  slotAddrNext;
   logic [127:0] slotDataNext;
   logic [15:0]  slotOpmNext;
   logic [15:0]  slotSeqNext;

   logic isLoadReq, isStoreReq, mmioHit, slotEmpty, mmioAccept;

`ifndef RBI_MMIO_EXC_EN
   // Fault codes are not reported in this build.
   logic unusedExc;
   assign unusedExc = ^mmioExcIn;
`endif

   // Request opcodes are 8'b1000_0sss (load) and 8'b1010_0sss (store).
   assign isLoadReq  = (memOpmIn[7:3] == 5'b10000);
   assign isStoreReq = (memOpmIn[7:3] == 5'b10100);
   assign mmioHit    = (isLoadReq || isStoreReq) &&
                       (memAddrIn[47:32] == 16'h0000) &&
                       (memAddrIn[31:28] == 4'hF);
   assign slotEmpty  = (memOpmIn[7:0] == 8'h00);
   assign mmioAccept = (mmioOK == MMIO_OK) || (mmioOK == MMIO_FAULT);

   always_comb begin
      stateNext       = stateReg;
      reqAddrNext     = reqAddrReg;
      reqSeqNext      = reqSeqReg;
      reqIsLoadNext   = reqIsLoadReg;
      respCodeNext    = respCodeReg;
      respDataNext    = respDataReg;
      mmioAddrNext    = mmioAddr;
      mmioOpmNext     = mmioOpm;
      mmioOutDataNext = mmioOutData;
      // By default the slot passes through unchanged.
      slotAddrNext    = memAddrIn;
      slotDataNext    = memDataIn;
      slotOpmNext     = memOpmIn;
      slotSeqNext     = memSeqIn;

      case (stateReg)
         ST_IDLE: begin
            if (mmioHit) begin
               reqAddrNext     = memAddrIn;
               reqSeqNext      = memSeqIn;
               reqIsLoadNext   = isLoadReq;
               mmioAddrNext    = memAddrIn[31:0];
               mmioOpmNext     = {(isLoadReq ? 2'b01 : 2'b10), memOpmIn[2:0]};
               mmioOutDataNext = memDataIn[63:0];
               // The request is consumed: the slot leaves this stop empty.
               slotAddrNext    = '0;
               slotDataNext    = '0;
               slotOpmNext     = '0;
               slotSeqNext     = '0;
               stateNext       = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mmioAccept) begin
               respCodeNext = reqIsLoadReg ? RSP_LOAD : RSP_STORE;
               respDataNext = '0;
`ifdef RBI_MMIO_EXC_EN
               if (mmioOK == MMIO_FAULT) begin
                  respCodeNext = RSP_FAULT;
                  respDataNext = mmioExcIn;
               end else if (reqIsLoadReg) begin
                  respDataNext = mmioInData;
               end
`else
               // A fault is acknowledged like OK but returns no data.
               if (reqIsLoadReg && (mmioOK == MMIO_OK)) begin
                  respDataNext = mmioInData;
               end
`endif
               mmioOpmNext = 5'd0;
               stateNext   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (mmioOK == MMIO_READY) begin
               stateNext = ST_RESP;
            end
         end
         default: begin
            // ST_RESP: wait for an empty slot. Occupied slots (including new
            // MMIO requests) keep circulating.
            if (slotEmpty) begin
               slotAddrNext = reqAddrReg;
               slotDataNext = {64'h0, respDataReg};
               slotOpmNext  = {unitNodeId, respCodeReg};
               slotSeqNext  = reqSeqReg;
               stateNext    = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateReg     <= ST_IDLE;
         reqAddrReg   <= '0;
         reqSeqReg    <= '0;
         reqIsLoadReg <= 1'b0;
         respCodeReg  <= '0;
         respDataReg  <= '0;
         mmioAddr     <= '0;
         mmioOpm      <= '0;
         mmioOutData  <= '0;
         memAddrOut   <= '0;
         memDataOut   <= '0;
         memOpmOut    <= '0;
         memSeqOut    <= '0;
      end else begin
         stateReg     <= stateNext;
         reqAddrReg   <= reqAddrNext;
         reqSeqReg    <= reqSeqNext;
         reqIsLoadReg <= reqIsLoadNext;
         respCodeReg  <= respCodeNext;
         respDataReg  <= respDataNext;
         mmioAddr     <= mmioAddrNext;
         mmioOpm      <= mmioOpmNext;
         mmioOutData  <= mmioOutDataNext;
         memAddrOut   <= slotAddrNext;
         memDataOut   <= slotDataNext;
         memOpmOut    <= slotOpmNext;
         memSeqOut    <= slotSeqNext;
      end
   end

endmodule

// File: tb/tb_rbi_mem_l2_mmio.sv
// -----------------------------------------------------------------------------
// tb_rbi_mem_l2_mmio
//   Directed bench for rbi_mem_l2_mmio: a table of pass-through ring slots,
//   plus hand-written sequences for load, store, collision, delayed
//   injection, fault and mid-transaction reset.
// -----------------------------------------------------------------------------
module tb_rbi_mem_l2_mmio;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [47:0]  memAddrIn = '0;
   logic [127:0] memDataIn = '0;
   logic [15:0]  memOpmIn = '0;
   logic [15:0]  memSeqIn = '0;
   logic [47:0]  memAddrOut;
   logic [127:0] memDataOut;
   logic [15:0]  memOpmOut;
   logic [15:0]  memSeqOut;
   logic [7:0]   unitNodeId = 8'h86;
   logic [31:0]  mmioAddr;
   logic [4:0]   mmioOpm;
   logic [63:0]  mmioOutData;
   logic [63:0]  mmioInData = '0;
   logic [1:0]   mmioOK = 2'b00;
   logic [63:0]  mmioExcIn = '0;

   int nVec = 0;
   int nMis = 0;

   rbi_mem_l2_mmio dut (
      .clock(clock), .reset(reset),
      .memAddrIn(memAddrIn), .memDataIn(memDataIn), .memOpmIn(memOpmIn), .memSeqIn(memSeqIn),
      .memAddrOut(memAddrOut), .memDataOut(memDataOut), .memOpmOut(memOpmOut), .memSeqOut(memSeqOut),
      .unitNodeId(unitNodeId),
      .mmioAddr(mmioAddr), .mmioOpm(mmioOpm), .mmioOutData(mmioOutData),
      .mmioInData(mmioInData), .mmioOK(mmioOK), .mmioExcIn(mmioExcIn)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [47:0]  addr;
      logic [127:0] data;
      logic [15:0]  opm;
      logic [15:0]  seq;
      logic [47:0]  expAddr;
      logic [127:0] expData;
      logic [15:0]  expOpm;
      logic [15:0]  expSeq;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic drive(input logic [47:0] a, input logic [127:0] d,
                        input logic [15:0] o, input logic [15:0] s);
      memAddrIn = a;
      memDataIn = d;
      memOpmIn  = o;
      memSeqIn  = s;
   endtask

   task automatic driveEmpty();
      drive(48'h0, 128'h0, 16'h0, 16'h0);
   endtask

   // Feed empty slots until a response appears on the ring, then compare it.
   task automatic expectResp(input string name, input logic [47:0] a, input logic [63:0] d,
                             input logic [7:0] code, input logic [15:0] s);
      bit got;
      got = 1'b0;
      driveEmpty();
      mmioOK = 2'b00;
      for (int i = 0; i < 12 && !got; i++) begin
         step();
         if (memOpmOut[7:6] == 2'b01) got = 1'b1;
      end
      if (!got) begin
         nVec++;
         nMis++;
         $display("FAIL %s: got no response within 12 cycles, want opm %h", name, {8'h86, code});
      end else begin
         check({name, ".opm"},  {112'h0, memOpmOut}, {112'h0, 8'h86, code});
         check({name, ".seq"},  {112'h0, memSeqOut}, {112'h0, s});
         check({name, ".addr"}, {80'h0, memAddrOut}, {80'h0, a});
         check({name, ".data"}, memDataOut, {64'h0, d});
         step();
         check({name, ".single"}, {112'h0, memOpmOut}, 128'h0);
      end
   endtask

   initial begin
      vecs[0] = '{48'h0000_0100_0000, 128'h1111, 16'h0083, 16'h0101,
                  48'h0000_0100_0000, 128'h1111, 16'h0083, 16'h0101};
      vecs[1] = '{48'h0001_F000_0000, 128'h2222, 16'h0383, 16'h0202,
                  48'h0001_F000_0000, 128'h2222, 16'h0383, 16'h0202};
      vecs[2] = '{48'h0000_F000_0040, 128'h3333, 16'h1260, 16'h0303,
                  48'h0000_F000_0040, 128'h3333, 16'h1260, 16'h0303};
      vecs[3] = '{48'h0000_E000_0000, 128'h4444, 16'h00A3, 16'h0404,
                  48'h0000_E000_0000, 128'h4444, 16'h00A3, 16'h0404};
      vecs[4] = '{48'h0000_F000_0000, 128'h5555, 16'h00C3, 16'h0505,
                  48'h0000_F000_0000, 128'h5555, 16'h00C3, 16'h0505};
      vecs[5] = '{48'h0000_0000_0000, 128'h0, 16'h0000, 16'h0000,
                  48'h0000_0000_0000, 128'h0, 16'h0000, 16'h0000};

      // Reset holds the ring outputs empty even with traffic at the input.
      drive(48'h0000_0100_0000, 128'hABCD, 16'h0083, 16'h0707);
      step(); step();
      check("reset.memOpmOut", {112'h0, memOpmOut}, 128'h0);
      check("reset.mmioOpm",   {123'h0, mmioOpm},   128'h0);
      check("reset.mmioAddr",  {96'h0, mmioAddr},   128'h0);
      reset = 1'b1;

      // Pass-through table: no slot here is an MMIO hit.
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].addr, vecs[i].data, vecs[i].opm, vecs[i].seq);
         step();
         check($sformatf("pass[%0d]", i),
               {memAddrOut, memOpmOut, memSeqOut, memDataOut[47:0]},
               {vecs[i].expAddr, vecs[i].expOpm, vecs[i].expSeq, vecs[i].expData[47:0]});
         check($sformatf("pass[%0d].data", i), memDataOut, vecs[i].expData);
      end

      // Load, with a HOLD phase and a colliding store request while busy.
      drive(48'h0000_F000_E000, 128'h9999_0000_0000_0000_0000, 16'h0583, 16'h1234);
      step();
      check("load.consumed", {112'h0, memOpmOut}, 128'h0);
      check("load.mmioOpm",  {123'h0, mmioOpm},   {123'h0, 5'b01011});
      check("load.mmioAddr", {96'h0, mmioAddr},   {96'h0, 32'hF000_E000});
      mmioOK = 2'b10;
      drive(48'h0000_F000_0080, 128'h77, 16'h00A1, 16'h4321);
      step();
      check("collide.pass", {memAddrOut, memOpmOut, memSeqOut, memDataOut[47:0]},
            {48'h0000_F000_0080, 16'h00A1, 16'h4321, 48'h77});
      driveEmpty();
      step();
      check("load.hold", {123'h0, mmioOpm}, {123'h0, 5'b01011});
      mmioOK = 2'b01;
      mmioInData = 64'hDEAD_BEEF;
      step();
      check("load.doneOpm", {123'h0, mmioOpm}, 128'h0);
      mmioInData = 64'h0;
      expectResp("load.resp", 48'h0000_F000_E000, 64'hDEAD_BEEF, 8'h60, 16'h1234);

      // Store returns an ack with zero data.
      drive(48'h0000_F000_0010, 128'h55AA, 16'h00A2, 16'h8702);
      step();
      check("store.mmioOutData", {64'h0, mmioOutData}, 128'h55AA);
      check("store.mmioOpm",     {123'h0, mmioOpm},    {123'h0, 5'b10010});
      driveEmpty();
      mmioOK = 2'b01;
      step();
      expectResp("store.resp", 48'h0000_F000_0010, 64'h0, 8'h61, 16'h8702);

      // RESP with five back-to-back full slots: injection waits for an empty one.
      drive(48'h0000_F000_0030, 128'h0, 16'h0084, 16'h0055);
      step();
      driveEmpty();
      mmioOK = 2'b01;
      mmioInData = 64'h0123_4567_89AB_CDEF;
      step();
      mmioOK = 2'b00;
      mmioInData = 64'h0;
      for (int i = 0; i < 5; i++) begin
         drive(48'h0000_0000_1000 + 48'(i), 128'(i + 100), 16'h0301, 16'(16'h0900 + i));
         step();
         check($sformatf("full[%0d]", i), {memAddrOut, memOpmOut, memSeqOut},
               {48'h0000_0000_1000 + 48'(i), 16'h0301, 16'(16'h0900 + i)});
      end
      expectResp("delay.resp", 48'h0000_F000_0030, 64'h0123_4567_89AB_CDEF, 8'h60, 16'h0055);

      // FAULT during a load.
      drive(48'h0000_F000_0020, 128'h0, 16'h0083, 16'h0042);
      step();
      driveEmpty();
      mmioExcIn = 64'h8001;
      mmioOK = 2'b11;
      step();
      mmioExcIn = 64'h0;
`ifdef RBI_MMIO_EXC_EN
      expectResp("fault.resp", 48'h0000_F000_0020, 64'h8001, 8'h63, 16'h0042);
`else
      expectResp("fault.resp", 48'h0000_F000_0020, 64'h0, 8'h60, 16'h0042);
`endif

      // Reset in the middle of a transaction abandons it.
      drive(48'h0000_F000_0050, 128'h0, 16'h0083, 16'h0066);
      step();
      driveEmpty();
      reset = 1'b0;
      #1;
      check("midreset.mmioOpm", {123'h0, mmioOpm}, 128'h0);
      step();
      reset = 1'b1;
      mmioOK = 2'b01;
      step();
      mmioOK = 2'b00;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("midreset.quiet[%0d]", i), {112'h0, memOpmOut}, 128'h0);
      end
      check("midreset.mmioOpmIdle", {123'h0, mmioOpm}, 128'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
